// File: rtl/tft_fb_arbiter.sv
// tft_fb_arbiter: shares the framebuffer BRAM between decoder writes and
// TFT scan-out prefetch; FB_ARB_STATS_EN builds the underflow event counter.
module tft_fb_arbiter #(
  parameter int ADDR_W     = 19,
  parameter int FB_PIXELS  = 384000,
  parameter int FIFO_DEPTH = 16,
  parameter int LOW_WATER  = 8
) (
  input  logic              tft_sclk_33m,
  input  logic              srst,
  input  logic              frame_start,
  input  logic              disp_pop,
  output logic [15:0]       disp_data,
  output logic              disp_empty,
  output logic              disp_underflow,
  input  logic              dec_req,
  input  logic [ADDR_W-1:0] dec_addr,
  input  logic [15:0]       dec_data,
  output logic              dec_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [15:0]       mem_wdata,
  input  logic [15:0]       mem_rdata,
  output logic [15:0]       underflow_cnt
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int OW = CW + 1;
  localparam logic [CW:0] DEPTH_O = OW'(FIFO_DEPTH);
  localparam logic [CW:0] LOW_O = OW'(LOW_WATER);
  localparam logic [CW-1:0] FULL_C = CW'(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(FB_PIXELS - 1);

  typedef enum logic [1:0] {
    FLUSH,
    PREFILL,
    RUN
  } state_t;

  state_t state, nstate;

  logic [15:0]       fifo [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count, count_nxt;
  logic              inflight, ret;
  logic [ADDR_W-1:0] rd_addr;
  logic [CW:0]       occ;
  logic              push, pop, empty_pop;
  logic              grant_rd, grant_wr;

  // inflight: read on the bus now; ret: its data returns this cycle
  assign occ = {1'b0, count}
             + {{CW{1'b0}}, inflight}
             + {{CW{1'b0}}, ret};

  assign push      = ret && !frame_start;
  assign pop       = disp_pop && (count != '0) && !frame_start;
  assign empty_pop = disp_pop && (count == '0) && !frame_start;

  assign disp_empty = (count == '0);
  assign disp_data  = disp_empty ? 16'h0000 : fifo[rd_ptr];

  // next state and the RAM grant for the coming cycle
  always_comb begin
    nstate    = state;
    grant_rd  = 1'b0;
    grant_wr  = 1'b0;
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
    if (frame_start) begin
      nstate = FLUSH;
    end else begin
      case (state)
        FLUSH: begin
          nstate   = PREFILL;
          grant_rd = (occ < DEPTH_O);
        end
        PREFILL: begin
          if (count_nxt == FULL_C) nstate = RUN;
          grant_rd = (occ < DEPTH_O);
        end
        RUN: begin
          if (occ < LOW_O) grant_rd = 1'b1;
          else if (dec_req && !dec_ack) grant_wr = 1'b1;
          else if (occ < DEPTH_O) grant_rd = 1'b1;
        end
        default: nstate = FLUSH;
      endcase
    end
  end

  // FSM, FIFO bookkeeping, scan address and registered RAM port
  always_ff @(posedge tft_sclk_33m) begin
    if (!srst) begin
      state          <= FLUSH;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      inflight       <= 1'b0;
      ret            <= 1'b0;
      rd_addr        <= '0;
      disp_underflow <= 1'b0;
      dec_ack        <= 1'b0;
      mem_we         <= 1'b0;
      mem_addr       <= '0;
      mem_wdata      <= '0;
    end else begin
      state   <= nstate;
      dec_ack <= grant_wr;
      mem_we  <= grant_wr;
      if (grant_wr) begin
        mem_addr  <= dec_addr;
        mem_wdata <= dec_data;
      end else if (grant_rd) begin
        mem_addr <= rd_addr;
      end
      if (frame_start) begin
        wr_ptr         <= '0;
        rd_ptr         <= '0;
        count          <= '0;
        inflight       <= 1'b0;
        ret            <= 1'b0;
        rd_addr        <= '0;
        disp_underflow <= 1'b0;
      end else begin
        ret      <= inflight;
        inflight <= grant_rd;
        count    <= count_nxt;
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop) rd_ptr <= rd_ptr + 1'b1;
        if (grant_rd)
          rd_addr <= (rd_addr == LAST_A) ? '0 : rd_addr + 1'b1;
        if (empty_pop) disp_underflow <= 1'b1;
      end
    end
  end

  // FIFO storage, no reset needed
  always_ff @(posedge tft_sclk_33m) begin
    if (push) fifo[wr_ptr] <= mem_rdata;
  end

`ifdef FB_ARB_STATS_EN
  logic [15:0] ucnt;

  // saturating count of ignored pops; survives frame_start
  always_ff @(posedge tft_sclk_33m) begin
    if (!srst) ucnt <= '0;
    else if (empty_pop && ucnt != 16'hFFFF) ucnt <= ucnt + 1'b1;
  end

  assign underflow_cnt = ucnt;
`else
  assign underflow_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_tft_fb_arbiter.sv
// tb_tft_fb_arbiter: directed vectors plus scan-out scoreboard.
// Frame size shortened so the address wrap is reached quickly.
module tb_tft_fb_arbiter;

  localparam int FBP = 1000;

`ifdef FB_ARB_STATS_EN
  localparam logic [15:0] EXP_CNT = 16'd3;
`else
  localparam logic [15:0] EXP_CNT = 16'd0;
`endif

  logic        clk = 1'b0;
  logic        srst;
  logic        fs;
  logic        pop;
  logic [15:0] disp_data;
  logic        disp_empty;
  logic        disp_underflow;
  logic        req;
  logic [18:0] daddr;
  logic [15:0] ddata;
  logic        dec_ack;
  logic [18:0] mem_addr;
  logic        mem_we;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic [15:0] underflow_cnt;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  tft_fb_arbiter #(.FB_PIXELS(FBP)) dut (
    .tft_sclk_33m  (clk),
    .srst          (srst),
    .frame_start   (fs),
    .disp_pop      (pop),
    .disp_data     (disp_data),
    .disp_empty    (disp_empty),
    .disp_underflow(disp_underflow),
    .dec_req       (req),
    .dec_addr      (daddr),
    .dec_data      (ddata),
    .dec_ack       (dec_ack),
    .mem_addr      (mem_addr),
    .mem_we        (mem_we),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata),
    .underflow_cnt (underflow_cnt)
  );

  // synchronous RAM model, mem[i]=i after reset
  logic [15:0] ram [2048];
  always @(posedge clk) begin
    if (!srst) begin
      for (int i = 0; i < 2048; i++) ram[i] <= 16'(i);
    end else if (mem_we) begin
      ram[mem_addr[10:0]] <= mem_wdata;
    end
    mem_rdata <= ram[mem_addr[10:0]];
  end

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        fs;
    logic        pop;
    logic        req;
    logic [18:0] addr;
    logic [15:0] data;
    logic        e_empty;
    logic [15:0] e_dout;
    logic        e_ack;
    logic        e_we;
    logic        chk_a;
    logic [18:0] e_addr;
    logic [15:0] e_wdata;
    logic        e_uf;
  } vec_t;

  vec_t tbl [23];

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int exp;
    int nwr;
    int gap;
    int maxgap;
    logic ack_last;
    logic [15:0] want [3];

    for (int i = 0; i < 23; i++) begin
      tbl[i] = '{default: 0};
      tbl[i].fs = (i == 0);
      tbl[i].e_empty = (i < 3);
      if (i >= 1 && i <= 16) begin
        tbl[i].chk_a  = 1'b1;
        tbl[i].e_addr = 19'(i - 1);
      end
    end
    tbl[20].req = 1'b1;
    tbl[20].addr = 19'd1234;
    tbl[20].data = 16'hABCD;
    tbl[20].e_ack = 1'b1;
    tbl[20].e_we = 1'b1;
    tbl[20].chk_a = 1'b1;
    tbl[20].e_addr = 19'd1234;
    tbl[20].e_wdata = 16'hABCD;
    tbl[21].req = 1'b1;
    tbl[21].addr = 19'd1234;
    tbl[21].data = 16'hABCD;

    srst = 1'b0;
    fs = 1'b0;
    pop = 1'b0;
    req = 1'b0;
    daddr = '0;
    ddata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_empty", 64'(disp_empty), 64'd1);
    chk("rst_data", 64'(disp_data), 64'd0);
    chk("rst_ack", 64'(dec_ack), 64'd0);
    chk("rst_we", 64'(mem_we), 64'd0);
    chk("rst_addr", 64'(mem_addr), 64'd0);
    chk("rst_wdata", 64'(mem_wdata), 64'd0);
    chk("rst_uf", 64'(disp_underflow), 64'd0);
    chk("rst_cnt", 64'(underflow_cnt), 64'd0);
    srst = 1'b1;

    for (int i = 0; i < 23; i++) begin
      fs = tbl[i].fs;
      pop = tbl[i].pop;
      req = tbl[i].req;
      daddr = tbl[i].addr;
      ddata = tbl[i].data;
      @(posedge clk);
      #1;
      chk($sformatf("row%0d empty", i), 64'(disp_empty), 64'(tbl[i].e_empty));
      chk($sformatf("row%0d data", i), 64'(disp_data), 64'(tbl[i].e_dout));
      chk($sformatf("row%0d ack", i), 64'(dec_ack), 64'(tbl[i].e_ack));
      chk($sformatf("row%0d we", i), 64'(mem_we), 64'(tbl[i].e_we));
      chk($sformatf("row%0d uf", i), 64'(disp_underflow), 64'(tbl[i].e_uf));
      if (tbl[i].chk_a)
        chk($sformatf("row%0d addr", i), 64'(mem_addr), 64'(tbl[i].e_addr));
      if (tbl[i].e_we)
        chk($sformatf("row%0d wdata", i), 64'(mem_wdata), 64'(tbl[i].e_wdata));
    end

    // continuous scan-out across the frame wrap
    exp = 0;
    pop = 1'b1;
    for (int n = 0; n < 1010; n++) begin
      @(negedge clk);
      chk(n == FBP ? "wrap" : "scan", {disp_empty, disp_data},
          {1'b0, 16'(exp)});
      exp = (exp == FBP - 1) ? 0 : exp + 1;
      @(posedge clk);
      #1;
    end
    pop = 1'b0;
    chk("scan_uf", 64'(disp_underflow), 64'd0);
    repeat (24) @(posedge clk);
    #1;

    // decoder pressure while popping every cycle
    req = 1'b1;
    daddr = 19'd0;
    ddata = 16'hBEEF;
    pop = 1'b1;
    nwr = 0;
    gap = 0;
    maxgap = 0;
    ack_last = 1'b0;
    for (int n = 0; n < 24; n++) begin
      @(negedge clk);
      chk("press_scan", {disp_empty, disp_data}, {1'b0, 16'(exp)});
      exp = (exp == FBP - 1) ? 0 : exp + 1;
      @(posedge clk);
      #1;
      if (ack_last) begin
        if (nwr >= 8) begin
          req = 1'b0;
        end else begin
          daddr = 19'(1500 + nwr);
          ddata = 16'hC000 + 16'(nwr);
        end
      end
      ack_last = dec_ack;
      if (dec_ack) begin
        chk("press_wr", {mem_we, mem_addr, mem_wdata}, {1'b1, daddr, ddata});
        nwr++;
        gap = 0;
      end else if (req) begin
        gap++;
        if (gap > maxgap) maxgap = gap;
      end
    end
    chk("press_nwr", 64'(nwr), 64'd8);
    chk("press_gap_le9", 64'(maxgap <= 9), 64'd1);
    chk("press_uf", 64'(disp_underflow), 64'd0);

    // frame_start mid-run with reads in flight, then three empty pops
    fs = 1'b1;
    @(posedge clk);
    #1;
    fs = 1'b0;
    chk("fs_empty", 64'(disp_empty), 64'd1);
    chk("fs_data", 64'(disp_data), 64'd0);
    chk("fs_uf", 64'(disp_underflow), 64'd0);
    @(posedge clk);
    #1;
    chk("stale_drop1", 64'(disp_empty), 64'd1);
    chk("uf_set", 64'(disp_underflow), 64'd1);
    @(posedge clk);
    #1;
    chk("stale_drop2", 64'(disp_empty), 64'd1);
    @(posedge clk);
    #1;
    chk("first_px", {disp_empty, disp_data}, {1'b0, 16'hBEEF});
    chk("uf_hold", 64'(disp_underflow), 64'd1);
    chk("uf_cnt3", 64'(underflow_cnt), 64'(EXP_CNT));
    want[0] = 16'hBEEF;
    want[1] = 16'd1;
    want[2] = 16'd2;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("refill%0d", k), {disp_empty, disp_data},
          {1'b0, want[k]});
      @(posedge clk);
      #1;
    end
    pop = 1'b0;

    // second frame_start clears sticky flag but not the counter
    repeat (20) @(posedge clk);
    #1;
    pop = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    fs = 1'b1;
    @(posedge clk);
    #1;
    fs = 1'b0;
    pop = 1'b0;
    chk("uf_clear", 64'(disp_underflow), 64'd0);
    chk("cnt_keep", 64'(underflow_cnt), 64'(EXP_CNT));
    chk("fs2_empty", 64'(disp_empty), 64'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("fs2_head", {disp_empty, disp_data}, {1'b0, 16'hBEEF});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/tft_fb_arbiter.md
Name: tft_fb_arbiter

Overview:
- Shares the single-port framebuffer BRAM between the ETC2 decoder's pixel writes and the TFT scan-out path.
- Prefetches display pixels into a small show-ahead FIFO so the timing generator can pop one RGB565 pixel per active clock without stalling.
- Sits between the decoder output stage, the framebuffer RAM and the TFT timing generator.
- Owns the frame read address and the per-cycle RAM grant.

Parameters:
- ADDR_W, 19, framebuffer address width.
- FB_PIXELS, 384000, pixels per frame (800x480); read address wraps at FB_PIXELS-1.
- FIFO_DEPTH, 16, prefetch FIFO entries (power of 2).
- LOW_WATER, 8, occupancy below which display reads pre-empt decoder writes.

Ports:
- tft_sclk_33m  in  1  clock.
- srst  in  1  reset.
- frame_start  in  1  one-cycle pulse at vsync; restarts scan-out at address 0.
- disp_pop  in  1  consume the FIFO head (asserted while DE is high).
- disp_data  out  16  FIFO head pixel; 16'h0000 when empty.
- disp_empty  out  1  FIFO empty.
- disp_underflow  out  1  sticky: a pop occurred while empty; cleared by frame_start.
- dec_req  in  1  decoder write request.
- dec_addr  in  ADDR_W  decoder write address.
- dec_data  in  16  decoder write pixel.
- dec_ack  out  1  one-cycle pulse in the cycle the write is issued to RAM.
- mem_addr  out  ADDR_W  RAM address.
- mem_we  out  1  RAM write enable.
- mem_wdata  out  16  RAM write data.
- mem_rdata  in  16  RAM read data, valid 1 cycle after a read issue.
- underflow_cnt  out  16  underflow event counter (see Optional Feature).

Behaviour:
- Reset srst is synchronous, active-low; clock is tft_sclk_33m. All state updates on the rising edge.
- Reset values:
  - state=FLUSH; FIFO empty; rd_addr=0; in-flight flag=0.
  - dec_ack=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - disp_underflow=0, underflow_cnt=0; disp_empty=1, disp_data=0.
- FSM:
  - FLUSH: FIFO pointers cleared, rd_addr=0, any in-flight read discarded. Lasts exactly 1 cycle, then PREFILL.
  - PREFILL: issues a display read every cycle while (count + inflight) < FIFO_DEPTH. Decoder is never granted. Moves to RUN when count == FIFO_DEPTH.
  - RUN: per-cycle grant priority:
    1. Display read if (count + inflight) < LOW_WATER.
    2. Else the decoder write if dec_req=1.
    3. Else a display read if (count + inflight) < FIFO_DEPTH.
    4. Else idle.
  - frame_start in any state: next state FLUSH. It overrides pop, read return and grant in the same cycle. A decoder write issued in that same cycle still completes and acks.
- Display read:
  - mem_addr=rd_addr, mem_we=0, inflight=1.
  - Next cycle mem_rdata is pushed to the FIFO tail.
  - rd_addr increments modulo FB_PIXELS, so FB_PIXELS-1 wraps to 0.
- Decoder write:
  - mem_addr=dec_addr, mem_wdata=dec_data, mem_we=1, dec_ack=1 for that single cycle.
  - The decoder holds dec_req/dec_addr/dec_data stable until it sees dec_ack. It may deassert dec_req, or present the next write, in the cycle after dec_ack.
  - Maximum write latency in RUN is bounded by FIFO_DEPTH-LOW_WATER+1 cycles of display priority.
- FIFO:
  - Show-ahead: disp_data is the head combinationally; 16'h0000 when empty.
  - Same-cycle push and pop are allowed; count is unchanged.
  - Overflow is structurally impossible because in-flight reads are reserved in the occupancy check.
  - disp_pop while empty: ignored, disp_underflow set to 1 (sticky), and the pop does not advance rd_addr.
- Latency: first valid pixel at disp_data 3 cycles after the frame_start pulse (FLUSH, read issue, push).
- Widths: count is log2(FIFO_DEPTH)+1 bits. rd_addr compare uses the full ADDR_W bits.

Optional Feature:
- Macro FB_ARB_STATS_EN.
- When defined: underflow_cnt increments by 1 on every ignored pop-while-empty. It saturates at 16'hFFFF, is cleared only by srst, and is not cleared by frame_start.
- When undefined: underflow_cnt is tied to 16'h0000 and no counter logic is built. All other behaviour is identical.

Test Plan:
- Reset, then frame_start pulse with dec_req=0 and RAM preloaded with mem[i]=i.
  - Required: FIFO full after 18 cycles; disp_data=16'h0000→16'h0000 at head=address 0.
  - Popping 800 consecutive cycles returns 0..799 with no underflow.
- In RUN with FIFO full, hold dec_req=1, dec_addr=1234, dec_data=16'hABCD.
  - Required: dec_ack 1 cycle later; mem_we=1, mem_addr=1234, mem_wdata=16'hABCD in that same cycle.
- In RUN, pop continuously and hold dec_req=1 continuously.
  - Required: grants alternate so that occupancy never drops below LOW_WATER-1.
  - Required: the decoder is acked at least once every 9 cycles; disp_underflow stays 0.
- Force rd_addr near the end of the frame (pop until address 383999).
  - Required: the next fetched pixel comes from address 0.
- Assert frame_start mid-RUN while a read is in flight.
  - Required: the stale read data is discarded; FIFO empty the next cycle; the head after refill is mem[0]; disp_underflow is cleared.
- Pop 3 times during FLUSH/empty.
  - Required: disp_underflow=1; underflow_cnt=3 with FB_ARB_STATS_EN defined, 0 without; rd_addr is unaffected.
